pc_issue_unit: RTL and testbench

- Parametrised program-counter generator that replaces the free-running testbench PC in front of the fetch stage.
- Issues sequential PCs to fetch over a valid/ready handshake.
- Supports enable gating, downstream backpressure, branch/jump redirect with flush, and halt.
- Counts PCs accepted by fetch, for cycle/debug accounting.

---
 rtl/pc_issue_unit_if.sv | 11 +
 rtl/pc_issue_unit.sv | 78 +++++++
 tb/tb_pc_issue_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_issue_unit_if.sv
// rtl/pc_issue_unit_if.sv - PC-to-fetch valid/ready handshake bundle
interface pc_issue_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                pc_valid;
    logic                pc_ready;
    logic [PC_WIDTH-1:0] pc_out;

    modport master (output pc_valid, output pc_out, input pc_ready);
    modport slave  (input pc_valid, input pc_out, output pc_ready);
endinterface

// File: rtl/pc_issue_unit.sv
// rtl/pc_issue_unit.sv - sequential PC issuer with redirect, halt and issue counting
module pc_issue_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  PC_STEP      = 1,
    parameter int                  COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    pc_issue_unit_if.master        fetch,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] issue_count
);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] next_pc;
    logic                xfer;
    logic                take_redirect;
    logic                do_issue;

    assign xfer = fetch.pc_valid & fetch.pc_ready;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state: redirect outranks halt; redirect is meaningless before the first enable
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!redirect_valid && halt) state_next = HALT;
            HALT:    if (redirect_valid) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: redirect/issue qualifiers for the datapath and the halted flag
    always_comb begin
        halted        = (state == HALT);
        take_redirect = redirect_valid && (state != IDLE);
        // Halt stops new issue on the same edge it is seen; the held PC may still drain
        do_issue      = (state == RUN) && enable && !redirect_valid && !halt
                        && (!fetch.pc_valid || fetch.pc_ready);
    end

    // Output slot, sequential PC and handshake counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch.pc_valid <= 1'b0;
            fetch.pc_out   <= RESET_VECTOR;
            next_pc        <= RESET_VECTOR;
            issue_count    <= '0;
        end else begin
            // A transfer completing in a redirect cycle still counts
            if (xfer) issue_count <= issue_count + COUNT_WIDTH'(1);
            if (take_redirect) begin
                fetch.pc_valid <= 1'b0;
                next_pc        <= redirect_pc;
            end else if (do_issue) begin
                fetch.pc_out   <= next_pc;
                fetch.pc_valid <= 1'b1;
                next_pc        <= next_pc + STEP;
            end else if (xfer) begin
                fetch.pc_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_issue_unit.sv
// tb/tb_pc_issue_unit.sv - directed self-checking bench for pc_issue_unit
module tb_pc_issue_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        halted0, halted1, halted2;
    logic [31:0] count0;
    logic [7:0]  count1, count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    pc_issue_unit_if #(.PC_WIDTH(32)) f0 ();
    pc_issue_unit_if #(.PC_WIDTH(4))  f1 ();
    pc_issue_unit_if #(.PC_WIDTH(4))  f2 ();

    assign f0.pc_ready = ready;
    assign f1.pc_ready = ready;
    assign f2.pc_ready = ready;

    pc_issue_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'd0), .PC_STEP(1), .COUNT_WIDTH(32)) dut0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch(f0), .halted(halted0), .issue_count(count0));

    pc_issue_unit #(.PC_WIDTH(4), .RESET_VECTOR(4'd14), .PC_STEP(1), .COUNT_WIDTH(8)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[3:0]),
        .fetch(f1), .halted(halted1), .issue_count(count1));

    pc_issue_unit #(.PC_WIDTH(4), .RESET_VECTOR(4'd0), .PC_STEP(3), .COUNT_WIDTH(8)) dut2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[3:0]),
        .fetch(f2), .halted(halted2), .issue_count(count2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_main(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] cnt);
        check({tag, " valid"}, 64'(f0.pc_valid), 64'(v));
        if (v) check({tag, " pc"}, 64'(f0.pc_out), 64'(pc));
        check({tag, " count"}, 64'(count0), 64'(cnt));
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b0;
        step(); step();

        // Reset state
        check_main("rst", 1'b0, 32'd0, 32'd0);
        check("rst pc_out", 64'(f0.pc_out), 64'd0);
        check("rst halted", 64'(halted0), 64'd0);
        check("rst d1 pc_out", 64'(f1.pc_out), 64'd14);

        reset_n = 1'b1;
        step();
        check_main("idle no enable", 1'b0, 32'd0, 32'd0);

        // IDLE -> RUN edge issues nothing; first PC appears one cycle later
        enable = 1'b1; ready = 1'b1;
        step();
        check_main("idle to run", 1'b0, 32'd0, 32'd0);
        step();
        for (int i = 0; i < 7; i++) begin
            check_main($sformatf("stream %0d", i), 1'b1, 32'(i), 32'(i));
            check($sformatf("wrap rv14 %0d", i), 64'(f1.pc_out), 64'((14 + i) % 16));
            check($sformatf("wrap step3 %0d", i), 64'(f2.pc_out), 64'((3 * i) % 16));
            check($sformatf("step3 valid %0d", i), 64'(f2.pc_valid), 64'd1);
            if (i < 6) step();
        end

        // Backpressure: pc_out=6 held, enable dropped mid-stall must not disturb it
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_main($sformatf("stall %0d", i), 1'b1, 32'd6, 32'd6);
            enable = (i != 0);
        end
        ready = 1'b1; enable = 1'b1;
        step(); check_main("resume 7", 1'b1, 32'd7, 32'd7);
        step(); check_main("resume 8", 1'b1, 32'd8, 32'd8);

        // Redirect flushes an untransferred PC
        ready = 1'b0;
        step(); check_main("hold 8", 1'b1, 32'd8, 32'd8);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); check_main("redir flush", 1'b0, 32'd0, 32'd8);
        redirect_valid = 1'b0; ready = 1'b1;
        step(); check_main("redir 0x40", 1'b1, 32'h40, 32'd8);
        step(); check_main("redir 0x41", 1'b1, 32'h41, 32'd9);

        // Halt: held PC drains, then nothing issues
        halt = 1'b1;
        step();
        check_main("halt edge", 1'b0, 32'd0, 32'd10);
        check("halted on", 64'(halted0), 64'd1);
        halt = 1'b0;
        step();
        check_main("halt stay", 1'b0, 32'd0, 32'd10);
        check("halted stay", 64'(halted0), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        check_main("unhalt", 1'b0, 32'd0, 32'd10);
        check("halted off", 64'(halted0), 64'd0);
        redirect_valid = 1'b0;
        step(); check_main("after halt 0x10", 1'b1, 32'h10, 32'd10);
        step(); check_main("after halt 0x11", 1'b1, 32'h11, 32'd11);

        // Redirect coinciding with a transfer: the transfer counts
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step(); check_main("redir+xfer", 1'b0, 32'd0, 32'd12);
        redirect_valid = 1'b0;
        step(); check_main("redir 0x80", 1'b1, 32'h80, 32'd12);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step(); check_main("b2b first", 1'b0, 32'd0, 32'd13);
        redirect_pc = 32'h30;
        step(); check_main("b2b second", 1'b0, 32'd0, 32'd13);
        redirect_valid = 1'b0;
        step(); check_main("b2b 0x30", 1'b1, 32'h30, 32'd13);

        // Asynchronous reset between edges
        reset_n = 1'b0;
        #1;
        check_main("async rst", 1'b0, 32'd0, 32'd0);
        check("async rst pc_out", 64'(f0.pc_out), 64'd0);
        check("async rst halted", 64'(halted0), 64'd0);
        step();
        reset_n = 1'b1;
        // Redirect seen in IDLE must be ignored
        redirect_valid = 1'b1; redirect_pc = 32'h55;
        step(); check_main("restart idle", 1'b0, 32'd0, 32'd0);
        redirect_valid = 1'b0;
        step(); check_main("restart rv", 1'b1, 32'd0, 32'd0);
        step(); check_main("restart 1", 1'b1, 32'd1, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
